// File: rtl/seq_subtractor.sv
// Multi-cycle subtractor: diff = a - b - bin (mod 2^WIDTH), one CHUNK-bit slice per cycle.
// The slice is an adder fed with ~b and carry-in ~bin; the carry is registered between slices.
module seq_subtractor #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    generate
        if (WIDTH % CHUNK != 0) begin : g_bad_chunk
            $error("seq_subtractor: CHUNK must divide WIDTH");
        end
    endgenerate

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;

    logic [CHUNK-1:0] a_sl [N];
    logic [CHUNK-1:0] b_sl [N];
    logic [CHUNK:0]   sum;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_slice
            assign a_sl[gi] = a_q[gi*CHUNK +: CHUNK];
            assign b_sl[gi] = b_q[gi*CHUNK +: CHUNK];
        end
    endgenerate

    // Adding ~b plus the inverted borrow is subtraction; the final carry is the inverted borrow.
    assign sum = {1'b0, a_sl[idx_q]} + {1'b0, ~b_sl[idx_q]} + {{CHUNK{1'b0}}, carry_q};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        res_d   = res_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = ~bin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                res_d[int'(idx_q)*CHUNK +: CHUNK] = sum[CHUNK-1:0];
                carry_d = sum[CHUNK];
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    diff_d  = res_d;
                    bout_d  = ~sum[CHUNK];
                    ovf_d   = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (res_d[WIDTH-1] ^ a_q[WIDTH-1]);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_seq_subtractor.sv
// Self-checking bench for seq_subtractor: directed corner cases plus random operations
// compared against a plain-arithmetic reference model.
module tb_seq_subtractor;

    localparam int N = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] a;
    logic [63:0] b;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] diff;
    logic        bout;
    logic        ovf;

    int checks = 0;
    int errors = 0;

    seq_subtractor #(.WIDTH(64), .CHUNK(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One full transaction: accept, wait for result, hold off the consumer, then retire.
    task automatic do_op(input logic [63:0] oa, input logic [63:0] ob, input logic obin, input int hold);
        logic [64:0] full;
        logic [63:0] ed;
        logic        eb;
        logic        eo;
        int          lat;
        bit          seen;
        full = {1'b0, oa} - {1'b0, ob} - {64'd0, obin};
        ed   = full[63:0];
        eb   = full[64];
        eo   = (oa[63] != ob[63]) && (ed[63] != oa[63]);

        @(negedge clk);
        check("in_ready_idle", {63'd0, in_ready}, 64'd1);
        a = oa; b = ob; bin = obin; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = ~oa; b = ~ob; bin = ~obin;

        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid) seen = 1'b1;
            else check("in_ready_run", {63'd0, in_ready}, 64'd0);
        end
        check("latency", 64'(lat), 64'(N));
        check("diff", diff, ed);
        check("bout", {63'd0, bout}, {63'd0, eb});
        check("ovf", {63'd0, ovf}, {63'd0, eo});
        check("in_ready_done", {63'd0, in_ready}, 64'd0);

        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            bin = 1'($urandom);
            @(negedge clk);
            check("hold_valid", {63'd0, out_valid}, 64'd1);
            check("hold_diff", diff, ed);
            check("hold_bout", {63'd0, bout}, {63'd0, eb});
            check("hold_ovf", {63'd0, ovf}, {63'd0, eo});
            check("hold_in_ready", {63'd0, in_ready}, 64'd0);
        end

        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("retire_valid", {63'd0, out_valid}, 64'd0);
        check("retire_in_ready", {63'd0, in_ready}, 64'd1);
        check("retire_diff_kept", diff, ed);
        $display("op a=%h b=%h bin=%0d diff=%h bout=%0d ovf=%0d lat=%0d hold=%0d",
                 oa, ob, obin, diff, bout, ovf, lat, hold);
    endtask

    initial begin
        logic [63:0] ra;
        logic [63:0] rb;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; bin = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_diff", diff, 64'd0);
        check("rst_bout", {63'd0, bout}, 64'd0);
        check("rst_ovf", {63'd0, ovf}, 64'd0);

        // out_ready in IDLE must not disturb anything
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("idle_out_ready", {63'd0, out_valid}, 64'd0);

        do_op(64'd10, 64'd3, 1'b0, 0);
        do_op(64'd0, 64'd1, 1'b0, 0);
        do_op(64'h8000_0000_0000_0000, 64'd1, 1'b0, 0);
        do_op(64'h0100_0000_0000_0000, 64'd1, 1'b0, 0);
        do_op(64'd5, 64'd5, 1'b1, 0);
        do_op(64'd5, 64'd5, 1'b0, 0);
        do_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 5);

        // reset on the third RUN cycle discards the operation
        @(negedge clk);
        a = 64'd77; b = 64'd5; bin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        check("midrst_diff", diff, 64'd0);
        check("midrst_bout", {63'd0, bout}, 64'd0);
        $display("op reset mid-run in_ready=%0d out_valid=%0d diff=%h", in_ready, out_valid, diff);
        do_op(64'd100, 64'd58, 1'b0, 0);

        for (int t = 0; t < 40; t++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0: rb = ra;
                1: begin ra = 64'd1 << $urandom_range(0, 63); rb = 64'($urandom_range(0, 3)); end
                2: begin ra = 64'($urandom_range(0, 255)); rb = 64'($urandom_range(0, 255)); end
                default: ;
            endcase
            do_op(ra, rb, 1'($urandom), $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_subtractor.md
Name: seq_subtractor

Overview:
- Multi-cycle unsigned/two's-complement subtractor: diff = a - b - bin (mod 2^WIDTH).
- Operands are processed CHUNK bits per cycle through a CHUNK-wide full-adder slice, using inverted b and carry-in = ~bin; the borrow is registered between chunks.
- It is the inverse-operation companion to the team's 64-bit ripple-carry adder datapath.
- It trades latency for a short critical path, with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 64, operand and result width in bits.
- CHUNK, 8, bits processed per cycle. Must divide WIDTH; elaboration error otherwise.
- N is derived, not a parameter: N = WIDTH/CHUNK = cycles per operation.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operands valid
- in_ready  out  1  block can accept operands (high only in IDLE)
- a  in  WIDTH  minuend
- b  in  WIDTH  subtrahend
- bin  in  1  borrow in
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- diff  out  WIDTH  a - b - bin mod 2^WIDTH
- bout  out  1  borrow out; 1 iff a < b + bin (unsigned)
- ovf  out  1  signed overflow: sign(a) != sign(b) and sign(diff) != sign(a)

Behaviour:
- Reset (synchronous, any state): state=IDLE, in_ready=1, out_valid=0, diff=0, bout=0, ovf=0, chunk index=0. Any in-flight operation is discarded.
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1.
  - On in_valid && in_ready at an edge: latch a, b; set carry register = ~bin; idx=0; go to RUN.
  - a, b and bin are sampled only at this edge.
- RUN: in_ready=0, out_valid=0.
  - Each edge computes slice idx: {c, s} = a[idx] + ~b[idx] + carry, where a[idx]/b[idx] are the CHUNK-bit slices of the latched operands.
  - Write s into the result shift register at slice idx, store c, idx++.
  - The edge that processes idx=N-1 loads diff, sets bout = ~c, sets ovf per the rule above, sets out_valid=1 and goes to DONE.
- Latency: out_valid rises exactly N cycles after the accept edge (8 at defaults). When N=1, RUN lasts one cycle.
- DONE: out_valid=1, in_ready=0.
  - diff, bout and ovf are held stable until out_valid && out_ready at an edge.
  - At that edge: out_valid=0, go to IDLE. in_ready=1 in the following cycle; no same-cycle turnaround.
- diff/bout/ovf keep their last values after leaving DONE. They change only on DONE entry or reset.
- in_valid while not in IDLE: ignored; the operands are not captured.
- out_ready while not in DONE: ignored.
- Boundary cases:
  - Full-width wrap: 0 - 1 gives all ones with bout=1.
  - Borrow propagates across every chunk boundary through the registered carry.
  - bin=1 with a==b gives all ones with bout=1.
- Throughput: one operation per N+2 cycles minimum (accept, N RUN cycles, DONE handshake).

Test Plan (WIDTH=64, CHUNK=8):
- a=10, b=3, bin=0, out_ready=1 -> out_valid high 8 cycles after the accept edge; diff=7, bout=0, ovf=0; in_ready=1 one cycle after the DONE handshake.
- a=0, b=1, bin=0 -> diff=0xFFFF_FFFF_FFFF_FFFF, bout=1, ovf=0.
- a=0x8000_0000_0000_0000, b=1, bin=0 -> diff=0x7FFF_FFFF_FFFF_FFFF, bout=0, ovf=1. Separately, a=0x0100_0000_0000_0000, b=1 -> diff=0x00FF_FFFF_FFFF_FFFF (borrow crosses 7 chunks).
- a=5, b=5, bin=1 -> diff=all ones, bout=1, ovf=0. Separately, a=5, b=5, bin=0 -> diff=0, bout=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands -> out_valid, diff, bout and ovf stay constant, in_ready=0, new operands not captured; result retires on the first out_ready=1 edge.
- Reset mid-operation: rst=1 for one cycle on the 3rd RUN cycle -> next cycle in_ready=1, out_valid=0, diff=0. A following transaction a=100, b=58 yields diff=42 after 8 cycles.
